// File: rtl/uart_encode_if.sv
// ---------------------------------------------------------------------------
// uart_encode_if
//
// Bundles the button inputs and the UART/status outputs of uart_encode.
//   btn_attack, btn_up, btn_left, btn_down, btn_right : raw button levels
//   tx          : UART serial line, idles high
//   tx_busy     : high while a frame is on the line
//   fifo_full   : command queue full
//   fifo_empty  : command queue empty
//
// master : the side that drives the buttons and watches the line (board/bench)
// slave  : the encoder itself
// ---------------------------------------------------------------------------
interface uart_encode_if;
    logic btn_attack;
    logic btn_up;
    logic btn_left;
    logic btn_down;
    logic btn_right;
    logic tx;
    logic tx_busy;
    logic fifo_full;
    logic fifo_empty;

    modport master (
        output btn_attack, btn_up, btn_left, btn_down, btn_right,
        input  tx, tx_busy, fifo_full, fifo_empty
    );

    modport slave (
        input  btn_attack, btn_up, btn_left, btn_down, btn_right,
        output tx, tx_busy, fifo_full, fifo_empty
    );
endinterface

// File: rtl/uart_encode.sv
// ---------------------------------------------------------------------------
// uart_encode
//
// Turns press/release edges on the five player buttons into one-byte command
// codes, queues them in a small first-word fall-through FIFO and sends them
// as 8N1 UART frames so a second board or a PC can mirror the controls.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : uart_encode_if.slave (button levels in; tx, tx_busy, fifo_full,
//          fifo_empty out)
//
// Button index order inside this module is the enqueue priority:
//   0 attack, 1 up, 2 left, 3 down, 4 right (lowest index wins).
// ---------------------------------------------------------------------------
module uart_encode #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    uart_encode_if.slave  bus
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int NBTN  = 5;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    // Press codes packed by button index: K W A S D. Release sets bit 5.
    localparam logic [NBTN*8-1:0] PRESS_CODES = {8'h44, 8'h53, 8'h41, 8'h57, 8'h4B};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input path: synchronizer, previous level, pending flag + event type
    // ------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    logic [NBTN-1:0] prev_q,  prev_d;
    logic [NBTN-1:0] pend_q,  pend_d;
    logic [NBTN-1:0] rel_q,   rel_d;     // 1 = latest recorded event was a release
    logic [NBTN-1:0] rise, fall, grant;
    logic [7:0]      code [NBTN];

    logic            wr_en;
    logic            rd_en;
    logic [7:0]      wr_data;

    assign btn_raw = {bus.btn_right, bus.btn_down, bus.btn_left, bus.btn_up, bus.btn_attack};

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            assign sync1_d[gi] = btn_raw[gi];
            assign sync2_d[gi] = sync1_q[gi];
            assign prev_d[gi]  = sync2_q[gi];
            assign rise[gi]    = sync2_q[gi] & ~prev_q[gi];
            assign fall[gi]    = ~sync2_q[gi] & prev_q[gi];
            // A fresh edge keeps the flag set even in the cycle its previous
            // event is being enqueued, so the newer event is never lost.
            assign pend_d[gi]  = rise[gi] | fall[gi] | (pend_q[gi] & ~(grant[gi] & wr_en));
            assign rel_d[gi]   = (rise[gi] | fall[gi]) ? fall[gi] : rel_q[gi];
            assign code[gi]    = PRESS_CODES[gi*8 +: 8] | {2'b00, rel_q[gi], 5'b00000};
        end
    endgenerate

    // Fixed-priority pick of one pending button per cycle.
    always_comb begin
        grant   = '0;
        wr_data = 8'h00;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                wr_data  = code[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO: extra pointer bit separates full from empty
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    // Head is read combinationally (fall-through) so the transmitter can
    // load it in the same cycle it decides to start a frame.
    assign head = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    // A write into a full FIFO is accepted when the head leaves in the
    // same cycle; pending flags otherwise simply wait for space.
    assign wr_en = (|pend_q) && (!fifo_full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            rel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            rel_q    <= rel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM with registered line outputs
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             tx_busy_q;

    assign rd_en = (state_q == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_cnt_q <= '0;
                    tx_q       <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= head;
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        tx_busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        state_q    <= S_DATA;
                        tx_q       <= shift_q[0];
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= S_STOP;
                            tx_q      <= 1'b1;
                        end else begin
                            // Shift right so the next bit is always at [1] now, [0] after.
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        state_q    <= S_IDLE;
                        tx_busy_q  <= 1'b0;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;

endmodule
